// File: rtl/fft_out_reorder.sv
`default_nettype none
// fft_out_reorder: captures digit-reversed DFT core output into a buffer, then
// streams it out in natural order over valid/ready. Rev 1.0
module fft_out_reorder #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] last_address,
  input  logic [WIDTH-1:0]  di_re,
  input  logic [WIDTH-1:0]  di_im,
  input  logic              di_en,
  input  logic [ADDR_W-1:0] di_addr,
  input  logic              di_last,
  output logic [WIDTH-1:0]  do_re,
  output logic [WIDTH-1:0]  do_im,
  output logic              do_valid,
  input  logic              do_ready,
  output logic              do_last,
  output logic              busy,
  output logic              err_addr,
  output logic              err_count,
  output logic              err_overrun
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2*WIDTH-1:0] mem [2**ADDR_W];
  logic [2*WIDTH-1:0] r_rdata;

  logic [ADDR_W-1:0] r_n1;
  logic [CW-1:0]     r_wcnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_done;
  logic              r_pend;
  logic              r_pend_last;
  logic              r_valid;
  logic              r_dlast;
  logic [WIDTH-1:0]  r_do_re;
  logic [WIDTH-1:0]  r_do_im;
  logic              r_err_addr;
  logic              r_err_count;
  logic              r_err_overrun;

  logic              w_wr_evt;
  logic [ADDR_W-1:0] w_n1;
  logic              w_in_range;
  logic              w_wr_mem;
  logic [CW-1:0]     w_wcnt_inc;
  logic [CW-1:0]     w_n_total;
  logic              w_load;
  logic              w_consume;
  logic              w_done;
  logic              w_rd_en;

  // The first sample latches N-1 on the same edge, so compare against the live port in IDLE.
  assign w_n1       = (r_state == S_IDLE) ? last_address : r_n1;
  assign w_wr_evt   = di_en && (r_state != S_DRAIN);
  assign w_in_range = (di_addr <= w_n1);
  assign w_wr_mem   = w_wr_evt && w_in_range && rst;
  assign w_wcnt_inc = r_wcnt + CW'(1);
  assign w_n_total  = {1'b0, w_n1} + CW'(1);

  // Two-stage read pipe: RAM data register feeds the 1-deep output register.
  assign w_consume  = r_valid && do_ready;
  assign w_load     = r_pend && (!r_valid || do_ready);
  assign w_done     = w_consume && r_dlast;
  assign w_rd_en    = (r_state == S_DRAIN) && !r_rd_done && (!r_pend || w_load);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (di_en) w_state_nxt = di_last ? S_DRAIN : S_CAPTURE;
      S_CAPTURE: if (di_en && di_last) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_mem) mem[di_addr] <= {di_re, di_im};
    if (w_rd_en)  r_rdata <= mem[r_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_n1          <= '0;
      r_wcnt        <= '0;
      r_rd_addr     <= '0;
      r_rd_done     <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_last   <= 1'b0;
      r_valid       <= 1'b0;
      r_dlast       <= 1'b0;
      r_do_re       <= '0;
      r_do_im       <= '0;
      r_err_addr    <= 1'b0;
      r_err_count   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && di_en) r_n1 <= last_address;

      if (w_done)        r_wcnt <= '0;
      else if (w_wr_evt) r_wcnt <= w_wcnt_inc;

      if (w_wr_evt && !w_in_range) r_err_addr <= 1'b1;
      if (w_wr_evt && di_last && (w_wcnt_inc != w_n_total)) r_err_count <= 1'b1;
      if (di_en && r_state == S_DRAIN) r_err_overrun <= 1'b1;

      if (w_done) begin
        r_rd_addr <= '0;
        r_rd_done <= 1'b0;
      end else if (w_rd_en) begin
        if (r_rd_addr == r_n1) r_rd_done <= 1'b1;
        else                   r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end

      if (w_rd_en) begin
        r_pend      <= 1'b1;
        r_pend_last <= (r_rd_addr == r_n1);
      end else if (w_load) begin
        r_pend      <= 1'b0;
      end

      if (w_load) begin
        r_valid <= 1'b1;
        r_do_re <= r_rdata[2*WIDTH-1:WIDTH];
        r_do_im <= r_rdata[WIDTH-1:0];
        r_dlast <= r_pend_last;
      end else if (w_consume) begin
        r_valid <= 1'b0;
        r_dlast <= 1'b0;
      end
    end
  end

  assign do_re       = r_do_re;
  assign do_im       = r_do_im;
  assign do_valid    = r_valid;
  assign do_last     = r_dlast;
  assign busy        = (r_state != S_IDLE);
  assign err_addr    = r_err_addr;
  assign err_count   = r_err_count;
  assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// tb_fft_out_reorder: directed self-checking bench for fft_out_reorder. Rev 1.0
module tb_fft_out_reorder;

  localparam int WIDTH  = 18;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] last_address = '0;
  logic [WIDTH-1:0]  di_re = '0;
  logic [WIDTH-1:0]  di_im = '0;
  logic              di_en = 1'b0;
  logic [ADDR_W-1:0] di_addr = '0;
  logic              di_last = 1'b0;
  logic [WIDTH-1:0]  do_re;
  logic [WIDTH-1:0]  do_im;
  logic              do_valid;
  logic              do_ready = 1'b0;
  logic              do_last;
  logic              busy;
  logic              err_addr;
  logic              err_count;
  logic              err_overrun;

  int n_chk  = 0;
  int n_pass = 0;

  fft_out_reorder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .last_address(last_address),
    .di_re(di_re), .di_im(di_im), .di_en(di_en), .di_addr(di_addr), .di_last(di_last),
    .do_re(do_re), .do_im(do_im), .do_valid(do_valid), .do_ready(do_ready),
    .do_last(do_last), .busy(busy),
    .err_addr(err_addr), .err_count(err_count), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  function automatic int perm(input int i, input int n, input int r);
    return (i % r) * (n / r) + i / r;
  endfunction

  // Writes nw samples in digit-reversed order; optionally slips an out-of-range write in.
  task automatic write_xform(input int n, input int r, input int nw, input int base, input int badpos);
    int a;
    last_address = ADDR_W'(n - 1);
    for (int i = 0; i < nw; i++) begin
      if (i == badpos) begin
        di_en = 1'b1; di_addr = ADDR_W'(13); di_re = '1; di_im = '1; di_last = 1'b0;
        @(negedge clk);
      end
      a = perm(i, n, r);
      di_en   = 1'b1;
      di_addr = ADDR_W'(a);
      di_re   = WIDTH'(base + a);
      di_im   = WIDTH'(base + a + 500);
      di_last = (i == nw - 1);
      @(negedge clk);
    end
    di_en = 1'b0; di_last = 1'b0; last_address = ADDR_W'(3);
  endtask

  task automatic drain(input int n, input int base, input bit toggle, input int chk_upto,
                       input int ov_at, input string nm);
    int k = 0;
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, rdy;
    logic [WIDTH-1:0] pre = '0, pim = '0;
    while (k < n && cyc < 400) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      do_ready = rdy;
      if (cyc == ov_at) begin
        di_en = 1'b1; di_addr = '0; di_re = 18'h2AAAA; di_im = 18'h15555;
      end else begin
        di_en = 1'b0;
      end
      if (pv && !pr) begin
        n_chk++;
        if (do_valid !== 1'b1 || do_re !== pre || do_im !== pim || do_last !== pl)
          $display("FAIL %s hold k=%0d: got v=%b re=%0d im=%0d last=%b, want v=1 re=%0d im=%0d last=%b",
                   nm, k, do_valid, do_re, do_im, do_last, pre, pim, pl);
        else n_pass++;
      end
      if (!toggle && k > 0) begin
        n_chk++;
        if (do_valid !== 1'b1) $display("FAIL %s gap k=%0d: do_valid=%b want 1", nm, k, do_valid);
        else n_pass++;
      end
      if (do_valid === 1'b1 && rdy) begin
        if (k < chk_upto) begin
          n_chk++;
          if (do_re !== WIDTH'(base + k) || do_im !== WIDTH'(base + k + 500))
            $display("FAIL %s data k=%0d: got re=%0d im=%0d want re=%0d im=%0d",
                     nm, k, do_re, do_im, base + k, base + k + 500);
          else n_pass++;
        end
        n_chk++;
        if (do_last !== (k == n - 1)) $display("FAIL %s last k=%0d: got %b want %b", nm, k, do_last, (k == n - 1));
        else n_pass++;
        k++;
      end
      pv = do_valid; pr = rdy; pl = do_last; pre = do_re; pim = do_im;
      @(negedge clk);
      cyc++;
    end
    di_en = 1'b0;
    do_ready = 1'b0;
    n_chk++;
    if (k != n) $display("FAIL %s count: got %0d words want %0d", nm, k, n);
    else n_pass++;
    n_chk++;
    if (do_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s end: got valid=%b busy=%b want 0 0", nm, do_valid, busy);
    else n_pass++;
  endtask

  task automatic check_errs(input logic ea, input logic ec, input logic eo, input string nm);
    n_chk++;
    if ({err_addr, err_count, err_overrun} !== {ea, ec, eo})
      $display("FAIL %s errs: got %b%b%b want %b%b%b", nm, err_addr, err_count, err_overrun, ea, ec, eo);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || do_last !== 1'b0 || busy !== 1'b0 || do_re !== '0 || do_im !== '0)
      $display("FAIL reset outs: got v=%b l=%b busy=%b re=%0d im=%0d want all 0", do_valid, do_last, busy, do_re, do_im);
    else n_pass++;
    check_errs(1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_natural_order();
    write_xform(12, 3, 12, 0, -1);
    n_chk++;
    if (do_valid !== 1'b0 || busy !== 1'b1) $display("FAIL lat0: got valid=%b busy=%b want 0 1", do_valid, busy);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0) $display("FAIL lat1: do_valid=%b want 0", do_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b1) $display("FAIL lat2: do_valid=%b want 1", do_valid);
    else n_pass++;
    drain(12, 0, 1'b0, 12, -1, "natural");
    check_errs(1'b0, 1'b0, 1'b0, "natural");
  endtask

  task automatic test_backpressure();
    write_xform(12, 3, 12, 100, -1);
    drain(12, 100, 1'b1, 12, -1, "toggle");
    check_errs(1'b0, 1'b0, 1'b0, "toggle");
  endtask

  task automatic test_short_count();
    write_xform(60, 5, 59, 1000, -1);
    drain(60, 1000, 1'b0, 59, -1, "short");
    check_errs(1'b0, 1'b1, 1'b0, "short");
  endtask

  task automatic test_bad_addr();
    do_reset();
    write_xform(12, 3, 12, 2000, 3);
    drain(12, 2000, 1'b0, 12, -1, "badaddr");
    n_chk++;
    if (err_addr !== 1'b1 || err_overrun !== 1'b0)
      $display("FAIL badaddr errs: got addr=%b ovr=%b want 1 0", err_addr, err_overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    write_xform(12, 3, 12, 3000, -1);
    drain(12, 3000, 1'b0, 12, 4, "overrun");
    check_errs(1'b0, 1'b0, 1'b1, "overrun");
  endtask

  task automatic test_abort();
    int k = 0;
    int cyc = 0;
    write_xform(12, 3, 12, 4000, -1);
    do_ready = 1'b1;
    while (k < 5 && cyc < 50) begin
      if (do_valid === 1'b1) k++;
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (k != 5 || do_valid !== 1'b1) $display("FAIL abort pre: got %0d words valid=%b want 5 1", k, do_valid);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort: got valid=%b busy=%b want 0 0", do_valid, busy);
    else n_pass++;
    check_errs(1'b0, 1'b0, 1'b0, "abort");
    rst = 1'b1;
    do_ready = 1'b0;
    @(negedge clk);
    write_xform(12, 3, 12, 5000, -1);
    drain(12, 5000, 1'b0, 12, -1, "post_abort");
    check_errs(1'b0, 1'b0, 1'b0, "post_abort");
  endtask

  initial begin
    test_reset();
    test_natural_order();
    test_backpressure();
    test_short_count();
    test_bad_addr();
    test_overrun();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
